// File: rtl/seven_seg_scan_if.sv
// ============================================================================
// Module   : seven_seg_scan_if
// Brief    : Digit-value and display-drive bundle for the 7-segment scanner.
//            The blink_mask field exists only when BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_seg_scan_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_mask;
  logic       lz_blank;
`ifdef BLINK_EN
  logic [3:0] blink_mask;
`endif
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

`ifdef BLINK_EN
  modport master (output digit0, digit1, digit2, digit3, dp_mask, lz_blank, blink_mask,
                  input  an, seg, dp);
  modport slave  (input  digit0, digit1, digit2, digit3, dp_mask, lz_blank, blink_mask,
                  output an, seg, dp);
`else
  modport master (output digit0, digit1, digit2, digit3, dp_mask, lz_blank,
                  input  an, seg, dp);
  modport slave  (input  digit0, digit1, digit2, digit3, dp_mask, lz_blank,
                  output an, seg, dp);
`endif
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan.sv
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Time-multiplexed 4-digit common-anode 7-segment driver with
//            refresh prescaler, BCD decode, leading-zero blanking and DP.
//            Optional digit blinking is compiled in with `define BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DIV_W        = 17,
  parameter int BLINK_FRAMES = 125
) (
  input  logic             clk,
  input  logic             reset,
  seven_seg_scan_if.slave  bus
);

  localparam logic [DIV_W-1:0] c_pre_last = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] r_pre;
  logic [1:0]       r_sel;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_tick;
  logic [3:0]       w_digit;
  logic [6:0]       w_dec;
  logic             w_blank;
  logic [3:0]       w_an_next;
  logic [6:0]       w_seg_next;
  logic             w_dp_next;

  assign w_tick = (r_pre == c_pre_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_sel <= 2'd0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_sel <= r_sel + 2'd1;
    end
  end

`ifdef BLINK_EN
  localparam int c_fc_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(BLINK_FRAMES - 1);

  logic [c_fc_w-1:0] r_fc;
  logic              r_phase;

  // A frame ends on the tick that leaves the leftmost digit slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fc    <= '0;
      r_phase <= 1'b0;
    end else if (w_tick && r_sel == 2'd3) begin
      if (r_fc == c_fc_last) begin
        r_fc    <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fc <= r_fc + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_digit = bus.digit0;
    case (r_sel)
      2'd0:    w_digit = bus.digit0;
      2'd1:    w_digit = bus.digit1;
      2'd2:    w_digit = bus.digit2;
      default: w_digit = bus.digit3;
    endcase

    case (w_digit)
      4'd0:    w_dec = 7'b1000000;
      4'd1:    w_dec = 7'b1111001;
      4'd2:    w_dec = 7'b0100100;
      4'd3:    w_dec = 7'b0110000;
      4'd4:    w_dec = 7'b0011001;
      4'd5:    w_dec = 7'b0010010;
      4'd6:    w_dec = 7'b0000010;
      4'd7:    w_dec = 7'b1111000;
      4'd8:    w_dec = 7'b0000000;
      4'd9:    w_dec = 7'b0010000;
      default: w_dec = 7'b0111111;
    endcase

    w_blank = bus.lz_blank && (r_sel == 2'd3) && (bus.digit3 == 4'd0);
`ifdef BLINK_EN
    if (r_phase && bus.blink_mask[r_sel]) w_blank = 1'b1;
`endif

    w_an_next  = ~(4'b0001 << r_sel);
    w_seg_next = w_dec;
    w_dp_next  = ~bus.dp_mask[r_sel];
    if (w_blank) begin
      w_an_next  = 4'b1111;
      w_seg_next = 7'b1111111;
      w_dp_next  = 1'b1;
    end
  end

  // All three drive registers share one edge so a digit is never mixed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
// ============================================================================
// Module   : tb_seven_seg_scan
// Brief    : Scoreboard bench for seven_seg_scan (REFRESH_DIV=4); blink
//            checks are included when BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan;

  localparam int RD = 4;
  localparam int DW = 3;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_seg_scan_if bus ();

  seven_seg_scan #(.REFRESH_DIV(RD), .DIV_W(DW), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] sbq[$];

  int m_pre, m_sel, m_fc;
  bit m_ph;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] t [0:9];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
    return (v > 4'd9) ? 7'b0111111 : t[v];
  endfunction

  function automatic logic [11:0] model_out();
    logic [3:0] d;
    logic [3:0] an;
    logic       dk;
    d  = (m_sel == 0) ? bus.digit0 : (m_sel == 1) ? bus.digit1 :
         (m_sel == 2) ? bus.digit2 : bus.digit3;
    dk = bus.lz_blank && m_sel == 3 && bus.digit3 == 4'd0;
`ifdef BLINK_EN
    if (m_ph && bus.blink_mask[m_sel]) dk = 1'b1;
`endif
    if (dk) return 12'hFFF;
    an = 4'b1111;
    an[m_sel] = 1'b0;
    return {an, dec(d), ~bus.dp_mask[m_sel]};
  endfunction

  function automatic logic [11:0] outs();
    return {bus.an, bus.seg, bus.dp};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_sel = 0; m_fc = 0; m_ph = 1'b0;
  endtask

  task automatic step();
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    check("scan", outs(), sbq.pop_front());
    if (m_pre == RD - 1) begin
      m_pre = 0;
      if (m_sel == 3) begin
        if (m_fc == BF - 1) begin
          m_fc = 0;
          m_ph = ~m_ph;
        end else m_fc++;
      end
      m_sel = (m_sel + 1) % 4;
    end else m_pre++;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int s;
    int run;
    logic [3:0] last_an;
    reset = 1'b1;
    bus.digit3 = 4'd1; bus.digit2 = 4'd2; bus.digit1 = 4'd3; bus.digit0 = 4'd4;
    bus.dp_mask = 4'b0000; bus.lz_blank = 1'b0;
`ifdef BLINK_EN
    bus.blink_mask = 4'b0000;
`endif
    model_reset();

    // Basic rotation and slot timing
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_dark", outs(), 12'hFFF);
    end
    reset = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 1)  check("t1_e1",  outs(), {4'b1110, 7'b0011001, 1'b1});
      if (e == 5)  check("t1_e5",  outs(), {4'b1101, 7'b0110000, 1'b1});
      if (e == 13) check("t1_e13", outs(), {4'b0111, 7'b1111001, 1'b1});
      if (e == 17) check("t1_e17", outs(), {4'b1110, 7'b0011001, 1'b1});
    end

    // digit0 sweep through the decode table
    for (int v = 0; v < 16; v++) begin
      while (m_sel != 0) step();
      bus.digit0 = 4'(v);
      step();
      check("t2_dec", {5'd0, bus.seg}, {5'd0, dec(4'(v))});
    end
    check("t2_dash", {5'd0, bus.seg}, {5'd0, 7'b0111111});

    // Leading-zero blanking and decimal point
    bus.lz_blank = 1'b1; bus.digit3 = 4'd0; bus.dp_mask = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      s = m_sel;
      step();
      if (i >= 4 && s == 3) check("t3_lzb", outs(), 12'hFFF);
      if (i >= 4 && s == 2) check("t3_dp", {11'd0, bus.dp}, 12'd0);
    end
    bus.lz_blank = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s = m_sel;
      step();
      if (s == 3) check("t3_zero", {5'd0, bus.seg}, {5'd0, 7'b1000000});
    end

    // Asynchronous reset mid digit2 slot
    while (!(m_sel == 2 && m_pre == 1)) step();
    reset = 1'b1;
    #1;
    check("t4_async", outs(), 12'hFFF);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("t4_held", outs(), 12'hFFF);
    step();
    check("t4_first", outs(), {4'b1110, dec(bus.digit0), 1'b1});

`ifdef BLINK_EN
    bus.dp_mask = 4'b0000;
    bus.digit3 = 4'd1; bus.digit2 = 4'd2; bus.digit1 = 4'd3; bus.digit0 = 4'd4;
    bus.blink_mask = 4'b0001;
    pulse_reset();
    for (int i = 0; i < 96; i++) begin
      s = m_sel;
      step();
      if (s == 0)
        check("t5_blink", {11'd0, bus.an[0]}, {11'd0, ((i / 16) == 2 || (i / 16) == 3)});
      else
        check("t5_other", {11'd0, bus.an[s]}, 12'd0);
    end
    bus.blink_mask = 4'b0000;
`endif

    // Long run with changing, never-blanked digits
    bus.lz_blank = 1'b0;
    pulse_reset();
    run = 0;
    last_an = 4'b1111;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.digit0 = 4'($urandom_range(0, 15));
        bus.digit1 = 4'($urandom_range(0, 15));
        bus.digit2 = 4'($urandom_range(0, 15));
        bus.digit3 = 4'($urandom_range(1, 15));
        bus.dp_mask = 4'($urandom_range(0, 15));
      end
      step();
      check("t6_onehot", {11'd0, ($onehot(~bus.an) || bus.an == 4'b1111)}, 12'd1);
      if (bus.an != last_an) begin
        if (i > 0 && last_an != 4'b1111) check("t6_slot", 12'(run), 12'(RD));
        run = 1;
        last_an = bus.an;
      end else run++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
